// File: rtl/double_pulse_trigger_pkg.sv
// rtl/double_pulse_trigger_pkg.sv - shared state encoding, counter width and parameter defaults
package double_pulse_trigger_pkg;

  localparam int CNT_W = 16;
  localparam int LED_W = 7;

  localparam int unsigned MIN_DLY_DEF  = 25;
  localparam int unsigned WIN_LEN_DEF  = 2500;
  localparam int unsigned TRIG_LEN_DEF = 4;
  localparam int unsigned HOLD_LEN_DEF = 125;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT2   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/double_pulse_trigger_edge_detect.sv
// rtl/double_pulse_trigger_edge_detect.sv - one-register rising-edge detector
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/double_pulse_trigger.sv
// rtl/double_pulse_trigger.sv - double-pulse decay trigger; Decay_Time capture enabled by DOUBLE_PULSE_TIME_EN
module double_pulse_trigger
  import double_pulse_trigger_pkg::*;
#(
  parameter int unsigned MIN_DLY  = MIN_DLY_DEF,
  parameter int unsigned WIN_LEN  = WIN_LEN_DEF,
  parameter int unsigned TRIG_LEN = TRIG_LEN_DEF,
  parameter int unsigned HOLD_LEN = HOLD_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Pulse_In,
  output logic             Trig_Single,
  output logic             Trig_Double,
  output logic [LED_W-1:0] LED_Single,
  output logic [LED_W-1:0] LED_Double,
  output logic [CNT_W-1:0] Decay_Time,
  output logic             Decay_Valid
);

  localparam logic [CNT_W-1:0] MIN_K  = to_cnt(MIN_DLY);
  localparam logic [CNT_W-1:0] WIN_K  = to_cnt(WIN_LEN);
  localparam logic [CNT_W-1:0] TRIG_K = to_cnt(TRIG_LEN);
  localparam logic [CNT_W-1:0] HOLD_K = to_cnt(HOLD_LEN);
  localparam logic [CNT_W-1:0] ONE_K  = to_cnt(1);

  logic             rise_evt;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fire_entry;

  edge_detect u_edge_detect (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (Pulse_In),
    .rise (rise_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // One counter serves as the spacing k in WAIT2 and as the phase timer in FIRE/HOLDOFF.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fire_entry = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (rise_evt) begin
          state_next = ST_WAIT2;
          cnt_next   = ONE_K;
        end
      end
      ST_WAIT2: begin
        if (rise_evt && (cnt >= MIN_K)) begin
          state_next = ST_FIRE;
          cnt_next   = ONE_K;
          fire_entry = 1'b1;
        end else if (cnt >= WIN_K) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE_K;
        end
      end
      ST_FIRE: begin
        if (cnt >= TRIG_K) begin
          state_next = ST_HOLDOFF;
          cnt_next   = ONE_K;
        end else begin
          cnt_next = cnt + ONE_K;
        end
      end
      ST_HOLDOFF: begin
        if (cnt >= HOLD_K) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE_K;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Trig_Single <= 1'b0;
      Trig_Double <= 1'b0;
      LED_Single  <= '0;
      LED_Double  <= '0;
    end else begin
      Trig_Single <= rise_evt;
      Trig_Double <= (state_next == ST_FIRE);
      if (rise_evt) begin
        LED_Single <= LED_Single + 7'd1;
      end
      if (fire_entry) begin
        LED_Double <= LED_Double + 7'd1;
      end
    end
  end

`ifdef DOUBLE_PULSE_TIME_EN
  // cnt still holds k in the cycle the second edge is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Decay_Time  <= '0;
      Decay_Valid <= 1'b0;
    end else begin
      Decay_Valid <= fire_entry;
      if (fire_entry) begin
        Decay_Time <= cnt;
      end
    end
  end
`else
  assign Decay_Time  = '0;
  assign Decay_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_double_pulse_trigger.sv
// tb/tb_double_pulse_trigger.sv - self-checking bench for double_pulse_trigger
module tb_double_pulse_trigger;

  localparam int MIN  = 25;
  localparam int WIN  = 2500;
  localparam int TRG  = 4;
  localparam int HLD  = 125;
  localparam int MAXC = 27000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Pulse_In = 1'b0;
  logic        Trig_Single, Trig_Double, Decay_Valid;
  logic [6:0]  LED_Single, LED_Double;
  logic [15:0] Decay_Time;

  always #5 clk = ~clk;

  double_pulse_trigger #(
    .MIN_DLY (MIN),
    .WIN_LEN (WIN),
    .TRIG_LEN(TRG),
    .HOLD_LEN(HLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Pulse_In   (Pulse_In),
    .Trig_Single(Trig_Single),
    .Trig_Double(Trig_Double),
    .LED_Single (LED_Single),
    .LED_Double (LED_Double),
    .Decay_Time (Decay_Time),
    .Decay_Valid(Decay_Valid)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Event-level model: remembers the pending first edge time and the end of the busy period.
  bit model_ok = 1'b0;
  int mt, first_t, trig_end, block_end, led_s, led_d, exp_time;
  bit have_first, mprev, exp_s, exp_d, exp_v;

  task automatic model_clear();
    mt = 0; have_first = 0; mprev = 0; first_t = 0;
    trig_end = -1000000; block_end = -1000000;
    led_s = 0; led_d = 0; exp_time = 0;
    exp_s = 0; exp_d = 0; exp_v = 0;
    model_ok = 1'b1;
  endtask

  task automatic model_step();
    bit e;
    int d;
    e = Pulse_In && !mprev;
    mprev = Pulse_In;
    exp_v = 0;
    d = mt - first_t;
    if (e) begin
      led_s = (led_s + 1) % 128;
      if (mt > block_end) begin
        if (have_first && d >= MIN && d <= WIN) begin
          exp_v = 1; exp_time = d;
          trig_end = mt + TRG; block_end = mt + TRG + HLD;
          led_d = (led_d + 1) % 128;
          have_first = 0;
        end else if (!(have_first && d < MIN)) begin
          have_first = 1; first_t = mt;
        end
      end
    end
    exp_s = e;
    exp_d = (mt + 1 <= trig_end);
    mt++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_clear();
    if (model_ok) begin
      check("trig_single", int'(Trig_Single), int'(exp_s));
      check("trig_double", int'(Trig_Double), int'(exp_d));
      check("led_single", int'(LED_Single), led_s);
      check("led_double", int'(LED_Double), led_d);
`ifdef DOUBLE_PULSE_TIME_EN
      check("decay_valid", int'(Decay_Valid), int'(exp_v));
      check("decay_time", int'(Decay_Time), exp_time);
`else
      check("decay_valid_tied", int'(Decay_Valid), 0);
      check("decay_time_tied", int'(Decay_Time), 0);
`endif
    end
    if (rst_n && model_ok) model_step();
  end

  bit         lvl[MAXC];
  bit         log_s[MAXC];
  logic [6:0] log_ls[MAXC];
  int n_s, n_d, n_v, first_s, first_d, first_v, val_time;

  task automatic clear_lvl();
    foreach (lvl[i]) lvl[i] = 1'b0;
  endtask

  task automatic add_edge(input int e);
    lvl[e] = 1'b1;
    lvl[e+1] = 1'b1;
  endtask

  task automatic do_reset();
    Pulse_In = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int len, input int rst_at, input int rst_rel);
    n_s = 0; n_d = 0; n_v = 0;
    first_s = -1; first_d = -1; first_v = -1; val_time = 0;
    for (int cur = 0; cur < len; cur++) begin
      @(posedge clk);
      #1;
      log_s[cur]  = Trig_Single;
      log_ls[cur] = LED_Single;
      if (Trig_Single) begin n_s++; if (first_s < 0) first_s = cur; end
      if (Trig_Double) begin
        n_d++;
        if (first_d < 0) begin first_d = cur; val_time = int'(Decay_Time); end
      end
      if (Decay_Valid) begin n_v++; if (first_v < 0) first_v = cur; end
      if (cur == rst_at) rst_n = 1'b0;
      if (cur == rst_rel) rst_n = 1'b1;
      Pulse_In = lvl[cur];
    end
    Pulse_In = 1'b0;
  endtask

  initial begin
    // edges 10 and 510
    do_reset(); clear_lvl(); add_edge(10); add_edge(510);
    run(700, -1, -1);
    check("s1_single_cnt", n_s, 2);
    check("s1_first_single", first_s, 11);
    check("s1_first_double", first_d, 511);
    check("s1_double_width", n_d, 4);
    check("s1_led_single", int'(log_ls[699]), 2);
    check("s1_led_double", int'(LED_Double), 1);
`ifdef DOUBLE_PULSE_TIME_EN
    check("s1_valid_cycle", first_v, 511);
    check("s1_decay_time", val_time, 500);
    check("s1_valid_cnt", n_v, 1);
`else
    check("s1_valid_cycle", first_v, -1);
    check("s1_decay_time", val_time, 0);
`endif

    // afterpulse inside MIN_DLY is ignored
    do_reset(); clear_lvl(); add_edge(10); add_edge(20); add_edge(60);
    run(300, -1, -1);
    check("s2_first_double", first_d, 61);
    check("s2_double_width", n_d, 4);
    check("s2_led_single", int'(LED_Single), 3);
`ifdef DOUBLE_PULSE_TIME_EN
    check("s2_decay_time", val_time, 50);
`endif

    // edge one past the window restarts it
    do_reset(); clear_lvl(); add_edge(10); add_edge(2511); add_edge(2611);
    run(2800, -1, -1);
    check("s3_first_double", first_d, 2612);
    check("s3_double_width", n_d, 4);
    check("s3_led_double", int'(LED_Double), 1);
`ifdef DOUBLE_PULSE_TIME_EN
    check("s3_decay_time", val_time, 100);
`endif

    // edge exactly at the window limit
    do_reset(); clear_lvl(); add_edge(10); add_edge(2510);
    run(2700, -1, -1);
    check("s4_first_double", first_d, 2511);
`ifdef DOUBLE_PULSE_TIME_EN
    check("s4_decay_time", val_time, 2500);
`endif

    // holdoff edge opens no window
    do_reset(); clear_lvl(); add_edge(10); add_edge(110); add_edge(150); add_edge(260);
    run(500, -1, -1);
    check("s5_first_double", first_d, 111);
    check("s5_double_width", n_d, 4);
    check("s5_single_cnt", n_s, 4);
    check("s5_holdoff_single", int'(log_s[151]), 1);
    check("s5_led_double", int'(LED_Double), 1);

    // reset mid-window aborts the sequence
    do_reset(); clear_lvl(); add_edge(10); add_edge(400);
    run(500, 300, 305);
    check("s6_double_cnt", n_d, 0);
    check("s6_led_before", int'(log_ls[299]), 1);
    check("s6_led_in_reset", int'(log_ls[302]), 0);
    check("s6_led_at_400", int'(log_ls[400]), 0);
    check("s6_led_at_401", int'(log_ls[401]), 1);
    check("s6_led_double", int'(LED_Double), 0);

    // 130 double events wrap the LED counters
    do_reset(); clear_lvl();
    for (int i = 0; i < 130; i++) begin
      add_edge(10 + 200 * i);
      add_edge(40 + 200 * i);
    end
    run(26050, -1, -1);
    check("s7_led_double", int'(LED_Double), 2);
    check("s7_led_single", int'(LED_Single), 4);
    check("s7_double_cycles", n_d, 520);
`ifdef DOUBLE_PULSE_TIME_EN
    check("s7_valid_cnt", n_v, 130);
`else
    check("s7_valid_cnt", n_v, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
